misr_ora: RTL

Output response analyser for the LBIST path, at the opposite end of the 24-bit LFSR test pattern generator. It compacts the circuit-under-test response into a multiple-input signature register (MISR) for a fixed number of enabled patterns. It then compares the final signature against a golden value and reports done/pass to the BIST controller. Its `en` follows the same stall semantics as the TPG, so both ends stay pattern-aligned.

---
 rtl/lbist_pkg.sv | 15 +
 rtl/misr_core.sv | 42 ++++
 rtl/misr_ora.sv | 100 ++++++++++
 3 files changed

// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: default MISR/LFSR width, feedback
// polynomial and the output-response-analyser FSM state type.
package lbist_pkg;

    localparam int LBIST_N = 24;
    localparam logic [LBIST_N-1:0] LBIST_POLY = 24'hC20001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } ora_state_e;

endpackage

// File: rtl/misr_core.sv
// Galois multiple-input signature register.
// Ports: clk/rst_n, load_i (reload SEED), en_i (absorb din_i),
// din_i (response word), sig_o (current signature).
module misr_core #(
    parameter int           N    = 24,
    parameter logic [N-1:0] POLY = 24'hC20001,
    parameter logic [N-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] sig_o
);

    logic [N-1:0] sig_q;
    logic [N-1:0] sig_d;

    // Shift left; the bit falling off the top folds back through POLY.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = {sig_q[N-2:0], 1'b0}
                  ^ (sig_q[N-1] ? POLY : '0)
                  ^ din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/misr_ora.sv
// LBIST output response analyser: compacts NUM_PATTERNS enabled responses
// into a MISR, then compares against GOLDEN and reports done/pass.
// Ports: clk, rst_n (async low), en (stall when low), start (run request),
// din (CUT response), done/pass (result), signature (MISR contents).
// Optional macro MISR_X_MASK_EN adds din_mask (1 = force din bit to 0).
module misr_ora
    import lbist_pkg::*;
#(
    parameter int           N            = LBIST_N,
    parameter logic [N-1:0] POLY         = N'(LBIST_POLY),
    parameter logic [N-1:0] SEED         = '0,
    parameter int           NUM_PATTERNS = 1024,
    parameter logic [N-1:0] GOLDEN       = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] din,
`ifdef MISR_X_MASK_EN
    input  logic [N-1:0] din_mask,
`endif
    output logic         done,
    output logic         pass,
    output logic [N-1:0] signature
);

    localparam int CW = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

    ora_state_e    state_q;
    logic [CW-1:0] count_q;
    logic          done_q;
    logic          pass_q;
    logic [N-1:0]  din_eff;
    logic          load;
    logic          absorb;

`ifdef MISR_X_MASK_EN
    assign din_eff = din & ~din_mask;
`else
    assign din_eff = din;
`endif

    // start is only honoured when no run is in flight.
    assign load   = start
                  && (state_q == ST_IDLE || state_q == ST_DONE);
    assign absorb = en && (state_q == ST_COMPACT);

    misr_core #(
        .N    (N),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .en_i   (absorb),
        .din_i  (din_eff),
        .sig_o  (signature)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_COMPACT;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_COMPACT: begin
                    if (en) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST) begin
                            state_q <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    pass_q  <= (signature == GOLDEN);
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done = done_q;
    assign pass = pass_q;

endmodule
